// File: rtl/spi_slave_mode0_regif.sv
// -----------------------------------------------------------------------------
// spi_slave_mode0_regif
//
// SPI mode 0 slave (CPOL=0, CPHA=0). It converts 16-bit MSB-first frames into
// register-bus accesses. Frame layout: bit15 = R/W (1 = read), bits14:8 =
// address, bits7:0 = write data (ignored for reads). The block runs only on
// sclk. It samples on the rising edge and drives miso on the falling edge.
//
// Ports:
//   sclk         in   SPI clock, the only clock of the block
//   rst_n        in   asynchronous active-low reset
//   ss_n         in   slave select, active-low; high aborts or ends a frame
//   mosi         in   serial data from the master
//   miso         out  serial data to the master (0 when idle, never tri-stated)
//   addr_out     out  [6:0] register address of the current or last frame
//   data_out     out  [7:0] write data of the last write frame
//   write_enable out  write strobe, rising edge 16 to the next falling edge
//   data_in      in   [7:0] read data for addr_out (combinational register file)
//   done         out  frame-complete strobe, same timing as write_enable
//   rx_frame     out  [15:0] last complete received frame
// -----------------------------------------------------------------------------
module spi_slave_mode0_regif (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic        ss_n,
    input  logic        mosi,
    output logic        miso,
    output logic [6:0]  addr_out,
    output logic [7:0]  data_out,
    output logic        write_enable,
    input  logic [7:0]  data_in,
    output logic        done,
    output logic [15:0] rx_frame
);

    // Frame-local state is cleared by reset and also whenever ss_n is high.
    logic        clr_s;
    logic [3:0]  cnt_r;
    logic [15:0] shift_r;
    logic [15:0] shift_nxt_s;
    logic        addr_phase_s;
    logic        frame_end_s;
    logic        rw_r;
    logic [7:0]  tx_r;

    // The strobes are the XOR of a toggle set on the rising edge and a copy of
    // that toggle taken on the falling edge. A strobe therefore lasts from the
    // 16th rising edge to the next falling edge, and the block needs no
    // dual-edge flop. Both halves clear together when a frame is aborted, so a
    // stale difference cannot reappear in the next window.
    logic        we_rise_r;
    logic        we_fall_r;
    logic        done_rise_r;
    logic        done_fall_r;

    assign clr_s = (~rst_n) | ss_n;

    // Next shift value and the two decode points of a frame.
    always_comb begin
        shift_nxt_s  = {shift_r[14:0], mosi};
        addr_phase_s = (cnt_r == 4'd7);
        frame_end_s  = (cnt_r == 4'd15);
    end

    // Bit counter and receive shift register. The counter wraps to 0 after the 16th bit.
    always_ff @(posedge sclk or posedge clr_s) begin
        if (clr_s) begin
            cnt_r   <= 4'd0;
            shift_r <= 16'h0000;
        end else begin
            cnt_r   <= cnt_r + 4'd1;
            shift_r <= shift_nxt_s;
        end
    end

    // Strobe set toggles, flipped on the 16th rising edge.
    always_ff @(posedge sclk or posedge clr_s) begin
        if (clr_s) begin
            we_rise_r   <= 1'b0;
            done_rise_r <= 1'b0;
        end else if (frame_end_s) begin
            done_rise_r <= ~done_rise_r;
            if (!shift_nxt_s[15]) begin
                we_rise_r <= ~we_rise_r;
            end else begin
                we_rise_r <= we_rise_r;
            end
        end else begin
            we_rise_r   <= we_rise_r;
            done_rise_r <= done_rise_r;
        end
    end

    // Strobe acknowledge: the falling edge catches up with the set toggles.
    always_ff @(negedge sclk or posedge clr_s) begin
        if (clr_s) begin
            we_fall_r   <= 1'b0;
            done_fall_r <= 1'b0;
        end else begin
            we_fall_r   <= we_rise_r;
            done_fall_r <= done_rise_r;
        end
    end

    // Read data serializer. data_in is loaded one falling edge after addr_out
    // settles and then shifted MSB first during frame bits 7..0.
    always_ff @(negedge sclk or posedge clr_s) begin
        if (clr_s) begin
            tx_r <= 8'h00;
        end else if (rw_r && (cnt_r == 4'd8)) begin
            tx_r <= data_in;
        end else if (rw_r && (cnt_r >= 4'd9)) begin
            tx_r <= {tx_r[6:0], 1'b0};
        end else begin
            tx_r <= 8'h00;
        end
    end

    // Register-bus outputs. Only reset clears them, so they hold across ss_n high.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            addr_out <= 7'h00;
            data_out <= 8'h00;
            rx_frame <= 16'h0000;
            rw_r     <= 1'b0;
        end else if (!ss_n) begin
            if (addr_phase_s) begin
                addr_out <= shift_nxt_s[6:0];
                rw_r     <= shift_nxt_s[7];
            end else if (frame_end_s) begin
                addr_out <= shift_nxt_s[14:8];
                rx_frame <= shift_nxt_s;
                if (!shift_nxt_s[15]) begin
                    data_out <= shift_nxt_s[7:0];
                end else begin
                    data_out <= data_out;
                end
            end else begin
                addr_out <= addr_out;
            end
        end else begin
            addr_out <= addr_out;
        end
    end

    assign miso         = tx_r[7];
    assign write_enable = we_rise_r ^ we_fall_r;
    assign done         = done_rise_r ^ done_fall_r;

endmodule

// File: tb/tb_spi_slave_mode0_regif.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_mode0_regif
//
// Self-checking bench for spi_slave_mode0_regif. The bench acts as the SPI
// master and as a register-file array that feeds data_in. It predicts the
// outputs from the frame-level rules: what each complete or partial frame
// should leave behind, and the expected miso word.
// -----------------------------------------------------------------------------
module tb_spi_slave_mode0_regif;

    logic        sclk;
    logic        rst_n;
    logic        ss_n;
    logic        mosi;
    logic        miso;
    logic [6:0]  addr_out;
    logic [7:0]  data_out;
    logic        write_enable;
    logic [7:0]  data_in;
    logic        done;
    logic [15:0] rx_frame;

    logic [7:0]  regfile [0:127];

    int          n_cmp;
    int          n_fail;
    int          we_pulses;
    int          done_pulses;

    logic [6:0]  exp_addr;
    logic [7:0]  exp_data;
    logic [15:0] exp_rx;

    spi_slave_mode0_regif dut (
        .sclk         (sclk),
        .rst_n        (rst_n),
        .ss_n         (ss_n),
        .mosi         (mosi),
        .miso         (miso),
        .addr_out     (addr_out),
        .data_out     (data_out),
        .write_enable (write_enable),
        .data_in      (data_in),
        .done         (done),
        .rx_frame     (rx_frame)
    );

    assign data_in = regfile[addr_out];

    initial we_pulses = 0;
    initial done_pulses = 0;
    always @(posedge write_enable) we_pulses = we_pulses + 1;
    always @(posedge done) done_pulses = done_pulses + 1;

    // Clock nbits bits of w MSB first and collect miso at each master sampling edge.
    task automatic shift_bits(input logic [15:0] w, input int nbits, output logic [15:0] mw);
        mw = 16'h0000;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[15-i];
            #5;
            mw = {mw[14:0], miso};
            sclk = 1'b1;
            #10;
            sclk = 1'b0;
            #5;
        end
    endtask

    // Frame-level reference: the output state a frame of nbits bits should leave behind.
    task automatic model_frame(input logic [15:0] w, input int nbits);
        if (nbits >= 8) exp_addr = w[14:8];
        if (nbits == 16) begin
            exp_rx = w;
            if (!w[15]) exp_data = w[7:0];
        end
    endtask

    function automatic logic [15:0] model_miso(input logic [15:0] w);
        logic [6:0] a;
        a = w[14:8];
        return w[15] ? {8'h00, regfile[a]} : 16'h0000;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #7;
        n_cmp++; if ({addr_out, data_out, rx_frame} !== 31'h0) begin n_fail++; $display("FAIL reset_regs: got %h %h %h required 0", addr_out, data_out, rx_frame); end
        n_cmp++; if ({miso, write_enable, done} !== 3'b000) begin n_fail++; $display("FAIL reset_bits: got miso/we/done %b%b%b required 000", miso, write_enable, done); end
        rst_n = 1'b1;
        #10;
        n_cmp++; if ({addr_out, data_out, rx_frame} !== 31'h0) begin n_fail++; $display("FAIL reset_release: got %h %h %h required 0", addr_out, data_out, rx_frame); end
        exp_addr = 7'h00; exp_data = 8'h00; exp_rx = 16'h0000;
    endtask

    task automatic test_write(input logic [15:0] w);
        logic [15:0] mw;
        int we0, d0;
        we0 = we_pulses; d0 = done_pulses;
        ss_n = 1'b0; #10;
        shift_bits(w, 16, mw);
        model_frame(w, 16);
        ss_n = 1'b1; #10;
        n_cmp++; if (addr_out !== exp_addr) begin n_fail++; $display("FAIL write_addr: got %h required %h", addr_out, exp_addr); end
        n_cmp++; if (data_out !== exp_data) begin n_fail++; $display("FAIL write_data: got %h required %h", data_out, exp_data); end
        n_cmp++; if (rx_frame !== exp_rx) begin n_fail++; $display("FAIL write_rx: got %h required %h", rx_frame, exp_rx); end
        n_cmp++; if (we_pulses - we0 !== 1) begin n_fail++; $display("FAIL write_we_pulses: got %0d required 1", we_pulses - we0); end
        n_cmp++; if (done_pulses - d0 !== 1) begin n_fail++; $display("FAIL write_done_pulses: got %0d required 1", done_pulses - d0); end
        n_cmp++; if (mw !== 16'h0000) begin n_fail++; $display("FAIL write_miso: got %h required 0000", mw); end
        n_cmp++; if ({miso, write_enable, done} !== 3'b000) begin n_fail++; $display("FAIL write_idle: got miso/we/done %b%b%b required 000", miso, write_enable, done); end
    endtask

    task automatic test_read(input logic [15:0] w, input logic [15:0] exp_mw);
        logic [15:0] mw;
        int we0, d0;
        we0 = we_pulses; d0 = done_pulses;
        ss_n = 1'b0; #10;
        shift_bits(w, 16, mw);
        model_frame(w, 16);
        ss_n = 1'b1; #10;
        n_cmp++; if (mw !== exp_mw) begin n_fail++; $display("FAIL read_miso: got %h required %h", mw, exp_mw); end
        n_cmp++; if (done_pulses - d0 !== 1) begin n_fail++; $display("FAIL read_done_pulses: got %0d required 1", done_pulses - d0); end
        n_cmp++; if (we_pulses - we0 !== 0) begin n_fail++; $display("FAIL read_we_pulses: got %0d required 0", we_pulses - we0); end
        n_cmp++; if (data_out !== exp_data) begin n_fail++; $display("FAIL read_data_hold: got %h required %h", data_out, exp_data); end
        n_cmp++; if (rx_frame !== exp_rx) begin n_fail++; $display("FAIL read_rx: got %h required %h", rx_frame, exp_rx); end
        n_cmp++; if (addr_out !== exp_addr) begin n_fail++; $display("FAIL read_addr: got %h required %h", addr_out, exp_addr); end
    endtask

    task automatic test_partial();
        logic [15:0] mw;
        int we0, d0;
        we0 = we_pulses; d0 = done_pulses;
        ss_n = 1'b0; #10;
        shift_bits(16'h1234, 10, mw);
        model_frame(16'h1234, 10);
        ss_n = 1'b1; #10;
        n_cmp++; if ((we_pulses - we0) + (done_pulses - d0) !== 0) begin n_fail++; $display("FAIL partial_strobes: got %0d required 0", (we_pulses - we0) + (done_pulses - d0)); end
        n_cmp++; if (data_out !== exp_data) begin n_fail++; $display("FAIL partial_data: got %h required %h", data_out, exp_data); end
        n_cmp++; if (rx_frame !== exp_rx) begin n_fail++; $display("FAIL partial_rx: got %h required %h", rx_frame, exp_rx); end
        n_cmp++; if (addr_out !== exp_addr) begin n_fail++; $display("FAIL partial_addr: got %h required %h", addr_out, exp_addr); end
        test_write(16'h0711);
    endtask

    task automatic test_back_to_back();
        logic [15:0] mw;
        int we0, d0;
        we0 = we_pulses; d0 = done_pulses;
        ss_n = 1'b0; #10;
        shift_bits(16'h0201, 16, mw);
        model_frame(16'h0201, 16);
        shift_bits(16'h0302, 16, mw);
        model_frame(16'h0302, 16);
        ss_n = 1'b1; #10;
        n_cmp++; if (we_pulses - we0 !== 2) begin n_fail++; $display("FAIL b2b_we_pulses: got %0d required 2", we_pulses - we0); end
        n_cmp++; if (done_pulses - d0 !== 2) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d required 2", done_pulses - d0); end
        n_cmp++; if (addr_out !== exp_addr) begin n_fail++; $display("FAIL b2b_addr: got %h required %h", addr_out, exp_addr); end
        n_cmp++; if (data_out !== exp_data) begin n_fail++; $display("FAIL b2b_data: got %h required %h", data_out, exp_data); end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] mw;
        ss_n = 1'b0; #10;
        shift_bits(16'h8123, 9, mw);
        rst_n = 1'b0;
        #1;
        exp_addr = 7'h00; exp_data = 8'h00; exp_rx = 16'h0000;
        n_cmp++; if ({addr_out, data_out, rx_frame} !== 31'h0) begin n_fail++; $display("FAIL midrst_regs: got %h %h %h required 0", addr_out, data_out, rx_frame); end
        n_cmp++; if ({miso, write_enable, done} !== 3'b000) begin n_fail++; $display("FAIL midrst_bits: got %b%b%b required 000", miso, write_enable, done); end
        #10;
        rst_n = 1'b1;
        ss_n = 1'b1;
        #10;
        test_write(16'h05A3);
    endtask

    task automatic test_random();
        logic [15:0] mw;
        logic [15:0] w;
        int nfr, nb, we0, d0;
        for (int win = 0; win < 30; win++) begin
            for (int a = 0; a < 128; a++) regfile[a] = 8'($urandom);
            nfr = int'($urandom_range(3, 1));
            ss_n = 1'b0; #10;
            for (int f = 0; f < nfr; f++) begin
                w = 16'($urandom);
                nb = ((f == nfr - 1) && ($urandom_range(3, 0) == 0)) ? int'($urandom_range(15, 1)) : 16;
                we0 = we_pulses; d0 = done_pulses;
                shift_bits(w, nb, mw);
                model_frame(w, nb);
                if (nb == 16) begin
                    n_cmp++; if (mw !== model_miso(w)) begin n_fail++; $display("FAIL rand_miso w=%h: got %h required %h", w, mw, model_miso(w)); end
                    n_cmp++; if (we_pulses - we0 !== (w[15] ? 0 : 1)) begin n_fail++; $display("FAIL rand_we w=%h: got %0d pulses required %0d", w, we_pulses - we0, w[15] ? 0 : 1); end
                    n_cmp++; if (done_pulses - d0 !== 1) begin n_fail++; $display("FAIL rand_done w=%h: got %0d pulses required 1", w, done_pulses - d0); end
                end else begin
                    ss_n = 1'b1; #10;
                    n_cmp++; if ((we_pulses - we0) + (done_pulses - d0) !== 0) begin n_fail++; $display("FAIL rand_partial_strobes w=%h nb=%0d: got %0d required 0", w, nb, (we_pulses - we0) + (done_pulses - d0)); end
                end
                n_cmp++; if ({addr_out, data_out, rx_frame} !== {exp_addr, exp_data, exp_rx}) begin n_fail++; $display("FAIL rand_regs w=%h nb=%0d: got %h %h %h required %h %h %h", w, nb, addr_out, data_out, rx_frame, exp_addr, exp_data, exp_rx); end
            end
            ss_n = 1'b1; #10;
            n_cmp++; if (miso !== 1'b0) begin n_fail++; $display("FAIL rand_idle_miso: got %b required 0", miso); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        sclk = 1'b0;
        ss_n = 1'b1;
        mosi = 1'b0;
        rst_n = 1'b0;
        for (int a = 0; a < 128; a++) regfile[a] = 8'h00;
        #3;
        test_reset();
        test_write(16'h05A3);
        regfile[5] = 8'h55;
        test_read(16'h8500, 16'h0055);
        regfile[10] = 8'h00;
        test_read(16'h8A00, 16'h0000);
        test_partial();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
